// File: rtl/cache_metadata_array_if.sv
// rtl/cache_metadata_array_if.sv - request/response bundle for the cache metadata array
// master = cache controller side, slave = metadata array side
interface cache_metadata_array_if #(
  parameter int SETS = 128,
  parameter int WAYS = 4
);
  localparam int IDX_W  = $clog2(SETS);
  localparam int META_W = 2*WAYS + (WAYS-1);

  logic              inv_all;
  logic              init_busy;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_addr;
  logic              rd_valid;
  logic [META_W-1:0] rd_data;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_addr;
  logic [META_W-1:0] wr_data;
  logic              parity_err;

  modport master (
    output inv_all, rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  init_busy, rd_valid, rd_data, parity_err
  );

  modport slave (
    input  inv_all, rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output init_busy, rd_valid, rd_data, parity_err
  );
endinterface

// File: rtl/cache_metadata_array.sv
// rtl/cache_metadata_array.sv - per-set valid/dirty/PLRU store with 2-cycle reads and clear sweep
// Optional even-parity protection per entry: define CACHE_META_PARITY_EN.
module cache_metadata_array #(
  parameter int SETS = 128,
  parameter int WAYS = 4
) (
  input logic                    clk,
  input logic                    rst,
  cache_metadata_array_if.slave  bus
);
  localparam int IDX_W  = $clog2(SETS);
  localparam int META_W = 2*WAYS + (WAYS-1);
`ifdef CACHE_META_PARITY_EN
  localparam int ENT_W  = META_W + 1;
`else
  localparam int ENT_W  = META_W;
`endif
  localparam logic [IDX_W:0] CNT_LAST = (IDX_W+1)'(SETS - 1);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t            state_q, state_d;
  logic [IDX_W:0]    cnt_q, cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic [IDX_W-1:0]  rd_addr_q, rd_addr_d;
  logic              rd_valid_q, rd_valid_d;
  logic [META_W-1:0] rd_data_q, rd_data_d;

  logic [ENT_W-1:0]  mem [SETS];
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [ENT_W-1:0]  mem_wdata;
  logic [ENT_W-1:0]  rd_ent;
  logic              init_busy;
  logic              rd_acc;
  logic              wr_acc;

  always_comb begin
    init_busy = (state_q == ST_CLEAR);
    rd_acc    = bus.rd_en & ~init_busy;
    wr_acc    = bus.wr_en & ~init_busy;
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = bus.wr_addr;
    mem_wdata = '0;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q[IDX_W-1:0];
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: begin
        if (wr_acc) begin
          mem_we = 1'b1;
`ifdef CACHE_META_PARITY_EN
          mem_wdata = {^bus.wr_data, bus.wr_data};
`else
          mem_wdata = bus.wr_data;
`endif
        end
        // A same-cycle write lands first; the sweep then clears it.
        if (bus.inv_all) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase

    rd_pend_d = rd_acc;
    rd_addr_d = rd_acc ? bus.rd_addr : rd_addr_q;

    // Write-first: a write in the access cycle overrides the stored entry.
    rd_ent     = (mem_we && (mem_waddr == rd_addr_q)) ? mem_wdata : mem[rd_addr_q];
    rd_valid_d = rd_pend_q;
    rd_data_d  = rd_pend_q ? rd_ent[META_W-1:0] : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      rd_pend_q  <= 1'b0;
      rd_addr_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_addr_q  <= rd_addr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

`ifdef CACHE_META_PARITY_EN
  logic parity_err_q, parity_err_d;

  always_comb begin
    parity_err_d = rd_pend_q & (^rd_ent);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.init_busy = init_busy;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
endmodule

// File: tb/tb_cache_metadata_array.sv
// tb/tb_cache_metadata_array.sv - directed self-checking bench for cache_metadata_array
// Covers reset sweep, read latency, forwarding, back-to-back reads, inv_all and async reset.
module tb_cache_metadata_array;
  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   n;
  int   bad;
  int   q_addr[$];
  int   q_exp[$];

  cache_metadata_array_if #(.SETS(128), .WAYS(4)) bus ();

  cache_metadata_array #(.SETS(128), .WAYS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int addr, input int data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 7'(addr);
    bus.wr_data = 11'(data);
    tick();
    bus.wr_en   = 1'b0;
  endtask

  // Issues q_addr back to back and expects q_exp exactly two cycles after each request.
  task automatic run_reads(input string tag);
    int cnt;
    cnt = q_addr.size();
    for (int i = 0; i <= cnt; i++) begin
      if (i < cnt) begin
        bus.rd_en   = 1'b1;
        bus.rd_addr = 7'(q_addr[i]);
      end else begin
        bus.rd_en   = 1'b0;
      end
      tick();
      if (i == 0) begin
        check({tag, "_latency"}, 32'(bus.rd_valid), 32'd0);
      end else begin
        check({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
        check({tag, "_data"}, 32'(bus.rd_data), 32'(q_exp[i-1]));
        check({tag, "_perr"}, 32'(bus.parity_err), 32'd0);
      end
    end
    tick();
    check({tag, "_idle_valid"}, 32'(bus.rd_valid), 32'd0);
    check({tag, "_hold_data"}, 32'(bus.rd_data), 32'(q_exp[cnt-1]));
    q_addr.delete();
    q_exp.delete();
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    rst         = 1'b1;
    bus.inv_all = 1'b0;
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;

    // Reset values
    tick(); tick(); tick();
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check("rst_busy", 32'(bus.init_busy), 32'd1);
    check("rst_perr", 32'(bus.parity_err), 32'd0);

    // Power-on sweep: reads are dropped while busy
    rst         = 1'b0;
    bus.rd_en   = 1'b1;
    bus.rd_addr = 7'd7;
    n   = 0;
    bad = 0;
    while (bus.init_busy && n < 300) begin
      n++;
      if (bus.rd_valid !== 1'b0) bad++;
      tick();
    end
    bus.rd_en = 1'b0;
    check("sweep_len", 32'(n), 32'd128);
    tick();
    if (bus.rd_valid !== 1'b0) bad++;
    tick();
    if (bus.rd_valid !== 1'b0) bad++;
    check("no_valid_while_busy", 32'(bad), 32'd0);

    for (int i = 0; i < 128; i++) begin
      q_addr.push_back(i);
      q_exp.push_back(0);
    end
    run_reads("zero_after_reset");

    // Write then read
    wr(5, 'h5A3);
    q_addr.push_back(5);
    q_exp.push_back('h5A3);
    run_reads("wr_rd");

    // Forwarding: write to the registered read index in the access cycle
    wr(9, 'h123);
    bus.rd_en = 1'b1; bus.rd_addr = 7'd9;
    tick();
    bus.rd_en = 1'b0;
    wr(9, 'h7FF);
    check("fwd_valid", 32'(bus.rd_valid), 32'd1);
    check("fwd_data", 32'(bus.rd_data), 32'h7FF);

    wr(9, 'h2AA);
    bus.rd_en = 1'b1; bus.rd_addr = 7'd9;
    tick();
    bus.rd_en = 1'b0;
    wr(10, 'h03C);
    check("nofwd_data", 32'(bus.rd_data), 32'h2AA);
    tick();

    // Write in the same cycle as the read request is already in the array
    bus.rd_en = 1'b1; bus.rd_addr = 7'd9;
    wr(9, 'h111);
    bus.rd_en = 1'b0;
    tick();
    check("same_cycle_wr_data", 32'(bus.rd_data), 32'h111);
    tick();

    q_addr.push_back(10);
    q_exp.push_back('h03C);
    run_reads("set10");

    // Back-to-back reads
    for (int i = 0; i < 4; i++) wr(i, i + 1);
    for (int i = 0; i < 4; i++) begin
      q_addr.push_back(i);
      q_exp.push_back(i + 1);
    end
    run_reads("b2b");

`ifdef CACHE_META_PARITY_EN
    wr(2, 'h001);
    dut.mem[2][11] = ~dut.mem[2][11];
    bus.rd_en = 1'b1; bus.rd_addr = 7'd2;
    tick();
    bus.rd_en = 1'b0;
    tick();
    check("perr_valid", 32'(bus.rd_valid), 32'd1);
    check("perr_set", 32'(bus.parity_err), 32'd1);
    tick();
    check("perr_clear_idle", 32'(bus.parity_err), 32'd0);
    wr(2, 'h001);
    q_addr.push_back(2);
    q_exp.push_back('h001);
    run_reads("perr_clean");
`endif

    // inv_all sweep with coincident read/write and a mid-sweep write and re-request
    for (int i = 0; i < 128; i++) wr(i, i + 1);
    q_addr.push_back(127);
    q_exp.push_back('h080);
    run_reads("prefill");

    bus.inv_all = 1'b1;
    bus.rd_en   = 1'b1; bus.rd_addr = 7'd0;
    bus.wr_en   = 1'b1; bus.wr_addr = 7'd50; bus.wr_data = 11'h7FF;
    tick();
    bus.inv_all = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_en   = 1'b0;
    n = 0;
    while (bus.init_busy && n < 300) begin
      n++;
      if (n == 2) begin
        check("inv_rd_valid", 32'(bus.rd_valid), 32'd1);
        check("inv_rd_fwd_clear", 32'(bus.rd_data), 32'd0);
      end
      if (n == 40) begin
        bus.wr_en = 1'b1; bus.wr_addr = 7'd3; bus.wr_data = 11'h155;
        bus.inv_all = 1'b1;
      end else begin
        bus.wr_en = 1'b0;
        bus.inv_all = 1'b0;
      end
      tick();
    end
    bus.wr_en   = 1'b0;
    bus.inv_all = 1'b0;
    check("inv_sweep_len", 32'(n), 32'd128);

    for (int i = 0; i < 128; i++) begin
      q_addr.push_back(i);
      q_exp.push_back(0);
    end
    run_reads("zero_after_inv");

    // Asynchronous reset in the middle of a read
    wr(6, 'h0F0);
    bus.rd_en = 1'b1; bus.rd_addr = 7'd6;
    tick();
    bus.rd_en = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(bus.init_busy), 32'd1);
    check("async_rst_data", 32'(bus.rd_data), 32'd0);
    tick();
    check("async_rst_valid", 32'(bus.rd_valid), 32'd0);
    rst = 1'b0;
    n = 0;
    while (bus.init_busy && n < 300) begin
      n++;
      tick();
    end
    check("rst_resweep_len", 32'(n), 32'd128);
    q_addr.push_back(6);
    q_exp.push_back(0);
    run_reads("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
